// File: rtl/data_bus_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_router_pkg
// Purpose  : Shared constants and FSM state types for the data-bus router.
// Revision : 1.0 - initial release
// ============================================================================
package data_bus_router_pkg;

   localparam int         c_SEL_W       = 3;
   localparam logic [2:0] c_RESP_OKAY   = 3'b000;
   localparam logic [2:0] c_RESP_DECERR = 3'b011;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_XFER = 2'd1,
      W_RESP = 2'd2,
      W_ERR  = 2'd3
   } wstate_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2,
      R_ERR  = 2'd3
   } rstate_e;

endpackage : data_bus_router_pkg
`default_nettype wire

// File: rtl/data_bus_addr_match.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_addr_match
// Purpose  : Base/mask region compare with lowest-index-wins priority encode.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_addr_match
   import data_bus_router_pkg::*;
#(
   parameter int                      N_SLV    = 3,
   parameter int                      ADDR_W   = 64,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
)(
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               o_hit,
   output logic [c_SEL_W-1:0] o_idx,
   output logic [ADDR_W-1:0]  o_offset
);

   // Scan from the top down so the lowest matching index is the last writer.
   always_comb begin
      o_hit    = 1'b0;
      o_idx    = '0;
      o_offset = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            o_hit    = 1'b1;
            o_idx    = c_SEL_W'(i);
            o_offset = i_addr & ~SLV_MASK[i*ADDR_W +: ADDR_W];
         end
      end
   end

endmodule : data_bus_addr_match
`default_nettype wire

// File: rtl/data_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_router
// Purpose  : AXI-Lite 1-to-N_SLV router with locked routing and DECERR slave.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_router
   import data_bus_router_pkg::*;
#(
   parameter int                      N_SLV    = 3,
   parameter int                      ADDR_W   = 64,
   parameter int                      DATA_W   = 64,
   localparam int                     STRB_W   = DATA_W / 8,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {64'h5000_0000, 64'h4000_0000, 64'h8000_0000},
   parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {3{64'hFFFF_FFFF_F000_0000}}
)(
   input  logic                      clk,
   input  logic                      rst,
   // master side
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [ADDR_W-1:0]         AWADDR,
   input  logic [2:0]                AWPROT,
   input  logic                      WVALID,
   output logic                      WREADY,
   input  logic [DATA_W-1:0]         WDATA,
   input  logic [STRB_W-1:0]         WSTRB,
   output logic                      BVALID,
   input  logic                      BREADY,
   output logic [2:0]                BRESP,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   input  logic [ADDR_W-1:0]         ARADDR,
   input  logic [2:0]                ARPROT,
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic [DATA_W-1:0]         RDATA,
   output logic [2:0]                RRESP,
   // slave side
   output logic [N_SLV-1:0]          AWVALID_S,
   input  logic [N_SLV-1:0]          AWREADY_S,
   output logic [N_SLV*ADDR_W-1:0]   AWADDR_S,
   output logic [N_SLV*3-1:0]        AWPROT_S,
   output logic [N_SLV-1:0]          WVALID_S,
   input  logic [N_SLV-1:0]          WREADY_S,
   output logic [N_SLV*DATA_W-1:0]   WDATA_S,
   output logic [N_SLV*STRB_W-1:0]   WSTRB_S,
   input  logic [N_SLV-1:0]          BVALID_S,
   output logic [N_SLV-1:0]          BREADY_S,
   input  logic [N_SLV*3-1:0]        BRESP_S,
   output logic [N_SLV-1:0]          ARVALID_S,
   input  logic [N_SLV-1:0]          ARREADY_S,
   output logic [N_SLV*ADDR_W-1:0]   ARADDR_S,
   output logic [N_SLV*3-1:0]        ARPROT_S,
   input  logic [N_SLV-1:0]          RVALID_S,
   output logic [N_SLV-1:0]          RREADY_S,
   input  logic [N_SLV*DATA_W-1:0]   RDATA_S,
   input  logic [N_SLV*3-1:0]        RRESP_S
);

   wstate_e              r_wstate, w_wstate_nxt;
   logic                 r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
   logic [c_SEL_W-1:0]   r_wsel;
   logic [ADDR_W-1:0]    r_aw_off;

   rstate_e              r_rstate, w_rstate_nxt;
   logic                 r_ar_done, w_ar_done_nxt;
   logic [c_SEL_W-1:0]   r_rsel;
   logic [ADDR_W-1:0]    r_ar_off;

   logic                 w_aw_hit, w_ar_hit;
   logic [c_SEL_W-1:0]   w_aw_idx, w_ar_idx;
   logic [ADDR_W-1:0]    w_aw_off, w_ar_off;

   logic                 w_s_awready, w_s_wready, w_s_bvalid, w_s_arready, w_s_rvalid;
   logic [2:0]           w_s_bresp, w_s_rresp;
   logic [DATA_W-1:0]    w_s_rdata;

   data_bus_addr_match #(
      .N_SLV    (N_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_aw_match (
      .i_addr   (AWADDR),
      .o_hit    (w_aw_hit),
      .o_idx    (w_aw_idx),
      .o_offset (w_aw_off)
   );

   data_bus_addr_match #(
      .N_SLV    (N_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_ar_match (
      .i_addr   (ARADDR),
      .o_hit    (w_ar_hit),
      .o_idx    (w_ar_idx),
      .o_offset (w_ar_off)
   );

   // Pick the locked slave's inputs; a plain select, never an OR across slaves.
   always_comb begin
      w_s_awready = 1'b0;
      w_s_wready  = 1'b0;
      w_s_bvalid  = 1'b0;
      w_s_bresp   = '0;
      w_s_arready = 1'b0;
      w_s_rvalid  = 1'b0;
      w_s_rresp   = '0;
      w_s_rdata   = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (r_wsel == c_SEL_W'(i)) begin
            w_s_awready = AWREADY_S[i];
            w_s_wready  = WREADY_S[i];
            w_s_bvalid  = BVALID_S[i];
            w_s_bresp   = BRESP_S[i*3 +: 3];
         end
         if (r_rsel == c_SEL_W'(i)) begin
            w_s_arready = ARREADY_S[i];
            w_s_rvalid  = RVALID_S[i];
            w_s_rresp   = RRESP_S[i*3 +: 3];
            w_s_rdata   = RDATA_S[i*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------------------------------------------------------- write
   always_comb begin
      w_wstate_nxt  = r_wstate;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      AWREADY       = 1'b0;
      WREADY        = 1'b0;
      BVALID        = 1'b0;
      BRESP         = c_RESP_OKAY;
      AWVALID_S     = '0;
      AWADDR_S      = '0;
      AWPROT_S      = '0;
      WVALID_S      = '0;
      WDATA_S       = '0;
      WSTRB_S       = '0;
      BREADY_S      = '0;
      case (r_wstate)
         W_IDLE: begin
            if (AWVALID) begin
               w_wstate_nxt = w_aw_hit ? W_XFER : W_ERR;
            end
         end
         W_XFER: begin
            AWREADY = w_s_awready & ~r_aw_done;
            WREADY  = w_s_wready & ~r_w_done;
            for (int i = 0; i < N_SLV; i++) begin
               if (r_wsel == c_SEL_W'(i)) begin
                  AWVALID_S[i] = AWVALID & ~r_aw_done;
                  WVALID_S[i]  = WVALID & ~r_w_done;
                  if (!r_aw_done) begin
                     AWADDR_S[i*ADDR_W +: ADDR_W] = r_aw_off;
                     AWPROT_S[i*3 +: 3]           = AWPROT;
                  end
                  if (!r_w_done) begin
                     WDATA_S[i*DATA_W +: DATA_W] = WDATA;
                     WSTRB_S[i*STRB_W +: STRB_W] = WSTRB;
                  end
               end
            end
            w_aw_done_nxt = r_aw_done | (AWVALID & AWREADY);
            w_w_done_nxt  = r_w_done | (WVALID & WREADY);
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_wstate_nxt = W_RESP;
            end
         end
         W_RESP: begin
            BVALID = w_s_bvalid;
            BRESP  = w_s_bresp;
            for (int i = 0; i < N_SLV; i++) begin
               if (r_wsel == c_SEL_W'(i)) begin
                  BREADY_S[i] = BREADY;
               end
            end
            if (BVALID && BREADY) begin
               w_wstate_nxt  = W_IDLE;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end
         W_ERR: begin
            AWREADY       = ~r_aw_done;
            WREADY        = ~r_w_done;
            BVALID        = r_aw_done & r_w_done;
            BRESP         = BVALID ? c_RESP_DECERR : c_RESP_OKAY;
            w_aw_done_nxt = r_aw_done | (AWVALID & AWREADY);
            w_w_done_nxt  = r_w_done | (WVALID & WREADY);
            if (BVALID && BREADY) begin
               w_wstate_nxt  = W_IDLE;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate  <= W_IDLE;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_wsel    <= '0;
         r_aw_off  <= '0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
         if (r_wstate == W_IDLE && AWVALID) begin
            r_wsel   <= w_aw_idx;
            r_aw_off <= w_aw_off;
         end
      end
   end

   // ----------------------------------------------------------------- read
   always_comb begin
      w_rstate_nxt  = r_rstate;
      w_ar_done_nxt = r_ar_done;
      ARREADY       = 1'b0;
      RVALID        = 1'b0;
      RDATA         = '0;
      RRESP         = c_RESP_OKAY;
      ARVALID_S     = '0;
      ARADDR_S      = '0;
      ARPROT_S      = '0;
      RREADY_S      = '0;
      case (r_rstate)
         R_IDLE: begin
            if (ARVALID) begin
               w_rstate_nxt = w_ar_hit ? R_ADDR : R_ERR;
            end
         end
         R_ADDR: begin
            ARREADY = w_s_arready;
            for (int i = 0; i < N_SLV; i++) begin
               if (r_rsel == c_SEL_W'(i)) begin
                  ARVALID_S[i]                 = ARVALID;
                  ARADDR_S[i*ADDR_W +: ADDR_W] = r_ar_off;
                  ARPROT_S[i*3 +: 3]           = ARPROT;
               end
            end
            if (ARVALID && ARREADY) begin
               w_rstate_nxt = R_DATA;
            end
         end
         R_DATA: begin
            RVALID = w_s_rvalid;
            RDATA  = w_s_rdata;
            RRESP  = w_s_rresp;
            for (int i = 0; i < N_SLV; i++) begin
               if (r_rsel == c_SEL_W'(i)) begin
                  RREADY_S[i] = RREADY;
               end
            end
            if (RVALID && RREADY) begin
               w_rstate_nxt = R_IDLE;
            end
         end
         R_ERR: begin
            ARREADY       = ~r_ar_done;
            RVALID        = r_ar_done;
            RRESP         = r_ar_done ? c_RESP_DECERR : c_RESP_OKAY;
            w_ar_done_nxt = r_ar_done | (ARVALID & ARREADY);
            if (RVALID && RREADY) begin
               w_rstate_nxt  = R_IDLE;
               w_ar_done_nxt = 1'b0;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate  <= R_IDLE;
         r_ar_done <= 1'b0;
         r_rsel    <= '0;
         r_ar_off  <= '0;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_ar_done <= w_ar_done_nxt;
         if (r_rstate == R_IDLE && ARVALID) begin
            r_rsel   <= w_ar_idx;
            r_ar_off <= w_ar_off;
         end
      end
   end

endmodule : data_bus_router
`default_nettype wire

// File: tb/tb_data_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_router
// Purpose  : Directed self-checking bench for data_bus_router (3 slaves).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_router;

   localparam int N  = 3;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic clk, rst;
   logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic          ARVALID, ARREADY, RVALID, RREADY;
   logic [AW-1:0] AWADDR, ARADDR;
   logic [2:0]    AWPROT, ARPROT, BRESP, RRESP;
   logic [DW-1:0] WDATA, RDATA;
   logic [SW-1:0] WSTRB;
   logic [N-1:0]    AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;
   logic [N-1:0]    ARVALID_S, ARREADY_S, RVALID_S, RREADY_S;
   logic [N*AW-1:0] AWADDR_S, ARADDR_S;
   logic [N*3-1:0]  AWPROT_S, ARPROT_S, BRESP_S, RRESP_S;
   logic [N*DW-1:0] WDATA_S, RDATA_S;
   logic [N*SW-1:0] WSTRB_S;

   int checks   = 0;
   int failures = 0;

   data_bus_router dut (
      .clk(clk), .rst(rst),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
      .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S), .AWADDR_S(AWADDR_S), .AWPROT_S(AWPROT_S),
      .WVALID_S(WVALID_S), .WREADY_S(WREADY_S), .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S),
      .BVALID_S(BVALID_S), .BREADY_S(BREADY_S), .BRESP_S(BRESP_S),
      .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S), .ARADDR_S(ARADDR_S), .ARPROT_S(ARPROT_S),
      .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      AWVALID = 0; AWADDR = '0; AWPROT = '0; WVALID = 0; WDATA = '0; WSTRB = '0;
      BREADY = 0; ARVALID = 0; ARADDR = '0; ARPROT = '0; RREADY = 0;
      AWREADY_S = '0; WREADY_S = '0; BVALID_S = '0; BRESP_S = '0;
      ARREADY_S = '0; RVALID_S = '0; RDATA_S = '0; RRESP_S = '0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick(); tick();
      // reset state, with slaves presenting activity
      BVALID_S = 3'b111; RVALID_S = 3'b111; RDATA_S = {3{64'hFFFF}};
      settle();
      chk("rst_awready", AWREADY, 0);
      chk("rst_bvalid", BVALID, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_bready_s", BREADY_S, 0);
      chk("rst_awvalid_s", AWVALID_S, 0);
      rst = 1'b0;
      clear_inputs();
      tick();

      // ---- write to RAM, zero-wait slave
      AWVALID = 1; AWADDR = 64'h8000_0010; WVALID = 1; WDATA = 64'hDEAD_BEEF; WSTRB = 8'hFF;
      BREADY = 1; AWREADY_S = 3'b111; WREADY_S = 3'b111;
      settle();
      chk("wr_c0_awready", AWREADY, 0);
      chk("wr_c0_wready", WREADY, 0);
      chk("wr_c0_awvalid_s", AWVALID_S, 0);
      tick();
      settle();
      chk("wr_c1_awvalid_s", AWVALID_S, 3'b001);
      chk("wr_c1_awaddr_s", AWADDR_S, {64'h0, 64'h0, 64'h10});
      chk("wr_c1_wvalid_s", WVALID_S, 3'b001);
      chk("wr_c1_wdata_s", WDATA_S, {64'h0, 64'h0, 64'hDEAD_BEEF});
      chk("wr_c1_wstrb_s", WSTRB_S, 24'h0000FF);
      chk("wr_c1_awready", AWREADY, 1);
      chk("wr_c1_wready", WREADY, 1);
      tick();
      AWVALID = 0; WVALID = 0; BVALID_S = 3'b001; BRESP_S = '0;
      settle();
      chk("wr_c2_awvalid_s", AWVALID_S, 0);
      chk("wr_c2_bvalid", BVALID, 1);
      chk("wr_c2_bresp", BRESP, 3'b000);
      chk("wr_c2_bready_s", BREADY_S, 3'b001);
      tick();
      clear_inputs();
      settle();
      chk("wr_c3_bvalid", BVALID, 0);

      // ---- read from timer, 3 wait cycles
      ARVALID = 1; ARADDR = 64'h5000_0004; RREADY = 1; ARREADY_S = 3'b100;
      tick();
      settle();
      chk("rd_arvalid_s", ARVALID_S, 3'b100);
      chk("rd_araddr_s", ARADDR_S, {64'h4, 64'h0, 64'h0});
      chk("rd_arready", ARREADY, 1);
      tick();
      ARVALID = 0; ARREADY_S = '0;
      RDATA_S = {64'h0, 64'h0, 64'hFFFF}; RRESP_S = {3'b000, 3'b000, 3'b010};
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("rd_wait_rvalid", RVALID, 0);
         chk("rd_wait_rready_lo", RREADY_S[1:0], 0);
         tick();
      end
      RVALID_S = 3'b100; RDATA_S = {64'h1234, 64'h0, 64'hFFFF};
      settle();
      chk("rd_rvalid", RVALID, 1);
      chk("rd_rdata", RDATA, 64'h1234);
      chk("rd_rresp", RRESP, 3'b000);
      chk("rd_rready_s", RREADY_S, 3'b100);
      tick();
      clear_inputs();
      settle();
      chk("rd_done_rvalid", RVALID, 0);

      // ---- unmapped write
      AWVALID = 1; AWADDR = 64'h2000_0000; WVALID = 1; WDATA = 64'h77; WSTRB = 8'h0F;
      AWREADY_S = 3'b111; WREADY_S = 3'b111;
      tick();
      settle();
      chk("uw_awvalid_s", AWVALID_S, 0);
      chk("uw_wvalid_s", WVALID_S, 0);
      chk("uw_awready", AWREADY, 1);
      chk("uw_wready", WREADY, 1);
      chk("uw_bvalid_early", BVALID, 0);
      tick();
      AWVALID = 0; WVALID = 0;
      settle();
      chk("uw_bvalid", BVALID, 1);
      chk("uw_bresp", BRESP, 3'b011);
      chk("uw_awready_after", AWREADY, 0);
      tick();
      settle();
      chk("uw_bvalid_hold", BVALID, 1);
      BREADY = 1;
      tick();
      clear_inputs();
      settle();
      chk("uw_bvalid_clr", BVALID, 0);

      // ---- unmapped read
      ARVALID = 1; ARADDR = 64'h2000_0000; RREADY = 1; ARREADY_S = 3'b111;
      RDATA_S = {3{64'h5555}};
      tick();
      settle();
      chk("ur_arready", ARREADY, 1);
      chk("ur_arvalid_s", ARVALID_S, 0);
      tick();
      ARVALID = 0;
      settle();
      chk("ur_rvalid", RVALID, 1);
      chk("ur_rdata", RDATA, 0);
      chk("ur_rresp", RRESP, 3'b011);
      tick();
      clear_inputs();
      settle();
      chk("ur_rvalid_clr", RVALID, 0);

      // ---- W before AW, then AWADDR changed after the lock
      WVALID = 1; WDATA = 64'h55; WSTRB = 8'h01; WREADY_S = 3'b111; BREADY = 1;
      settle();
      chk("ord_wready_0", WREADY, 0);
      chk("ord_wvalid_s_0", WVALID_S, 0);
      tick();
      settle();
      chk("ord_wready_1", WREADY, 0);
      tick();
      AWVALID = 1; AWADDR = 64'h8000_0008;
      settle();
      chk("ord_wready_2", WREADY, 0);
      tick();
      AWADDR = 64'h4000_0000;
      settle();
      chk("ord_wready_lock", WREADY, 1);
      chk("ord_wvalid_s", WVALID_S, 3'b001);
      chk("ord_route_kept", AWVALID_S, 3'b001);
      tick();
      WVALID = 0; AWREADY_S = 3'b001;
      settle();
      chk("ord_wvalid_s_low", WVALID_S, 0);
      chk("ord_wready_low", WREADY, 0);
      chk("ord_route_kept2", AWVALID_S, 3'b001);
      chk("ord_awready", AWREADY, 1);
      tick();
      AWVALID = 0; BVALID_S = 3'b001;
      settle();
      chk("ord_bvalid", BVALID, 1);
      chk("ord_bready_s", BREADY_S, 3'b001);
      tick();
      clear_inputs();
      settle();
      chk("ord_bvalid_clr", BVALID, 0);

      // ---- concurrent read from RAM and write to VGA
      ARVALID = 1; ARADDR = 64'h8000_0000; ARREADY_S = 3'b111; RREADY = 1;
      tick();
      settle();
      chk("cc_arvalid_s", ARVALID_S, 3'b001);
      AWVALID = 1; AWADDR = 64'h4000_0000; WVALID = 1; WDATA = 64'hA5; WSTRB = 8'hFF;
      AWREADY_S = 3'b111; WREADY_S = 3'b111; BREADY = 1;
      tick();
      ARVALID = 0;
      settle();
      chk("cc_awvalid_s", AWVALID_S, 3'b010);
      chk("cc_wvalid_s", WVALID_S, 3'b010);
      chk("cc_arvalid_s_idle", ARVALID_S, 0);
      chk("cc_rready_s", RREADY_S, 3'b001);
      tick();
      AWVALID = 0; WVALID = 0;
      BVALID_S = 3'b010; BRESP_S = {3'b000, 3'b000, 3'b010};
      RVALID_S = 3'b001; RDATA_S = {64'h0, 64'h0, 64'hCAFE}; RRESP_S = '0;
      settle();
      chk("cc_bvalid", BVALID, 1);
      chk("cc_bresp", BRESP, 3'b000);
      chk("cc_bready_s", BREADY_S, 3'b010);
      chk("cc_rvalid", RVALID, 1);
      chk("cc_rdata", RDATA, 64'hCAFE);
      chk("cc_rresp", RRESP, 3'b000);
      chk("cc_rready_s2", RREADY_S, 3'b001);
      tick();
      clear_inputs();
      settle();
      chk("cc_bvalid_clr", BVALID, 0);
      chk("cc_rvalid_clr", RVALID, 0);

      // ---- reset in the middle of a write, then a clean write
      AWVALID = 1; AWADDR = 64'h8000_0020; WVALID = 1; WDATA = 64'h9; WSTRB = 8'hFF; BREADY = 1;
      tick();
      settle();
      chk("rs_xfer_awvalid_s", AWVALID_S, 3'b001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk("rs_awvalid_s", AWVALID_S, 0);
      chk("rs_wvalid_s", WVALID_S, 0);
      chk("rs_awaddr_s", AWADDR_S, 0);
      chk("rs_awready", AWREADY, 0);
      chk("rs_wready", WREADY, 0);
      AWREADY_S = 3'b001; WREADY_S = 3'b001;
      tick();
      settle();
      chk("rs_awaddr_s2", AWADDR_S, {64'h0, 64'h0, 64'h20});
      chk("rs_awready2", AWREADY, 1);
      chk("rs_wready2", WREADY, 1);
      tick();
      AWVALID = 0; WVALID = 0; BVALID_S = 3'b001;
      settle();
      chk("rs_bvalid", BVALID, 1);
      chk("rs_bresp", BRESP, 3'b000);
      tick();
      clear_inputs();
      settle();
      chk("rs_bvalid_clr", BVALID, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_data_bus_router
`default_nettype wire

// File: doc/data_bus_router.md
# data_bus_router

Parametrised AXI-Lite data-bus router: one master (the core's load/store unit) to `N_SLV` memory-mapped slaves, with per-slave base/mask decode, a routing lock held until each transaction's response completes, and a built-in default slave that returns DECERR for unmapped addresses. It sits between the LSU master port and the RAM, VGA, timer and future peripherals, replacing the fixed one-to-three combinational decoder. Read and write paths are independent, and each channel allows one outstanding transaction.

## Interface
Parameters:
- `N_SLV`, 3, number of slaves (1..8)
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; `STRB_W = DATA_W/8`
- `SLV_BASE`, {64'h5000_0000, 64'h4000_0000, 64'h8000_0000}, packed `N_SLV*ADDR_W`; slot i holds slave i's base
- `SLV_MASK`, {3{64'hFFFF_FFFF_F000_0000}}, packed; slot i holds the compare mask for slave i

Ports:
- `clk` in 1: the single clock
- `rst` in 1: synchronous reset, active-high
- Master side, AXI-Lite slave interface. Signals are `AW*`, `W*`, `B*`, `AR*`, `R*` with the usual directions.
  - `AWADDR`/`ARADDR`: `ADDR_W`
  - `WDATA`/`RDATA`: `DATA_W`
  - `WSTRB`: `STRB_W`
  - `AWPROT`/`ARPROT`: 3
  - `BRESP`/`RRESP`: 3
- Slave side, flat packed vectors, slot i belongs to slave i:
  - `AWVALID_S`, `WVALID_S`, `BREADY_S`, `ARVALID_S`, `RREADY_S`: out, `N_SLV`
  - `AWREADY_S`, `WREADY_S`, `BVALID_S`, `ARREADY_S`, `RVALID_S`: in, `N_SLV`
  - `AWADDR_S`, `ARADDR_S`: out, `N_SLV*ADDR_W`
  - `WDATA_S`: out, `N_SLV*DATA_W`
  - `RDATA_S`: in, `N_SLV*DATA_W`
  - `WSTRB_S`: out, `N_SLV*STRB_W`
  - `AWPROT_S`, `ARPROT_S`: out, `N_SLV*3`
  - `BRESP_S`, `RRESP_S`: in, `N_SLV*3`

## Operation
- **Decode.** Slave i matches when `(ADDR & SLV_MASK[i]) == SLV_BASE[i]`.
  - If several slaves match, the lowest index wins.
  - If none matches, the transaction is routed to the default (error) slave.
- **Address forwarded to a slave:** `ADDR & ~SLV_MASK[i]`, i.e. the offset within its region.
- **Unselected slave outputs:** all forced to 0 (valid, address, data, strobe, prot). `BREADY_S`/`RREADY_S` are 0 for every slave except the locked one.
- **Write FSM:** `W_IDLE` → `W_XFER` → `W_RESP`, or `W_IDLE` → `W_ERR`.
  - `W_IDLE`: `AWREADY=WREADY=0`. When `AWVALID=1`, latch the decoded index into `wsel` (or set the err flag) and go to `W_XFER`, or to `W_ERR` if unmapped.
  - `W_XFER`:
    - AW is forwarded to `wsel` until its handshake, which sets `aw_done`.
    - W is forwarded independently until its handshake, which sets `w_done`.
    - Once an AW/W handshake has occurred, valid to the slave and ready to the master are held low for that channel.
    - When both flags are set, go to `W_RESP`.
  - `W_RESP`: B is forwarded from `wsel`. The B handshake returns the FSM to `W_IDLE` and clears the flags.
  - `W_ERR`:
    - The router itself drives `AWREADY=1` until the AW handshake and `WREADY=1` until the W handshake.
    - After both, it drives `BVALID=1` with `BRESP=DECERR (3'b011)` until `BREADY`, then returns to `W_IDLE`.
- **Read FSM:** `R_IDLE` → `R_ADDR` → `R_DATA`, or `R_IDLE` → `R_ERR`.
  - Same pattern as the write FSM.
  - In `R_ERR`: `ARREADY=1` for one handshake, then `RVALID=1`, `RDATA=0`, `RRESP=DECERR` until `RREADY`.
- **Response pass-through:** `BRESP`/`RRESP`/`RDATA` from the locked slave are passed through unchanged. No ORing of responses across slaves.
- **W before AW:** W arriving before AW is not accepted. `WREADY=0` until the route is locked.

## Timing
- **Reset:** `W_IDLE`/`R_IDLE`, all flags and the sel registers 0. Every master- and slave-side output is 0 in the cycle after `rst` is sampled high.
- **Route latency:** one cycle. With `AWVALID` sampled at edge N, `AWVALID_S[wsel]` is high from cycle N+1.
- **Data path:** combinational between master and locked slave. No data is registered: `RVALID`→`RVALID_S` and `RDATA`→`RDATA_S` pass through with zero latency.
- **Minimum write, zero-wait slave:**
  - AW in cycle 0
  - AW/W handshake in cycle 1
  - `BVALID_S` in cycle 2
  - B handshake in cycle 2, with `W_IDLE` at cycle 3
- **Minimum read:** same; `R_IDLE` at cycle 3.
- **Master address changes:** changes on `AWADDR`/`ARADDR` after the lock do not move the route.
- **Independence:** read and write to the same or different slaves run concurrently with no interaction.
- **Reset mid-transaction:** both FSMs abort to idle. Slave-side valids drop the next cycle. No response is owed to the master.
- **Simultaneous AW and W handshake** in one cycle: both flags set, `W_RESP` the next cycle.

## Structure
- Add to `defines.v`:
  - `` `RespOkay `` (3'b000), `` `RespSlvErr `` (3'b010), `` `RespDecErr `` (3'b011)
  - FSM state encodings (2-bit)
  - `` `SelW `` = 3, the width of the latched slave index
- Sub-module `data_bus_addr_match`: combinational base/mask compare plus priority encoder. Outputs `hit`, `idx`, `offset`. Instantiated twice, once for AW and once for AR.
- The router top holds the two FSMs, the done flags, the sel registers and the muxes. Target size: 200–300 lines.

## Test plan
- **Write to RAM:** `AWADDR=64'h8000_0010`, `WDATA=64'hDEAD_BEEF`, `WSTRB=8'hFF`. Required: `AWADDR_S[0]=64'h10` with only `AWVALID_S[0]` high, and `BRESP=OKAY`, returned to the master at cycle 2.
- **Read from timer:** `ARADDR=64'h5000_0004`, slave 2 returns `64'h1234` after 3 wait cycles. Required: `RDATA=64'h1234`, `RRESP=OKAY`, and `RREADY_S[1:0]` held at 0 throughout.
- **Unmapped write:** `AWADDR=64'h2000_0000`. Required: no slave valid asserted, `AWREADY`/`WREADY` from the router, then `BVALID` with `BRESP=3'b011`. Unmapped read: `RDATA=0`, `RRESP=3'b011`.
- **Ordering and address change:** W presented 2 cycles before AW; `WREADY` stays 0 until the lock. Changing `AWADDR` to `64'h4000_0000` mid-transaction must not move the route.
- **Concurrency:** a write to VGA (`64'h4000_0000`) while a read from RAM (`64'h8000_0000`) is outstanding. Both complete with `OKAY`, with no cross-talk on the slave strobes.
- **Reset:** `rst` asserted during `W_XFER`. All outputs are 0 next cycle. A following transaction to `64'h8000_0020` completes normally.
